// File: rtl/jesd204_rx_cgs.sv
// Per-lane JESD204B RX code-group synchronisation: CS_INIT/CS_CHECK/CS_DATA state machine,
// SYNC~ generation, ILAS start detection and registered data forwarding with a valid qualifier.
module jesd204_rx_cgs #(
    parameter int unsigned CGS_K_WORDS  = 4,
    parameter int unsigned ERR_LIMIT    = 3,
    parameter int unsigned SYNC_MIN_LOW = 16,
    parameter int unsigned ERR_STAT_W   = 16
) (
    input  logic                  rxusrclk2_in,
    input  logic                  rx_reset_n_in,
    input  logic                  rx_reset_done_in,
    input  logic                  rxbyteisaligned_in,
    input  logic [31:0]           rxdata_in,
    input  logic [3:0]            rxctrl0_in,
    input  logic [3:0]            rxctrl1_in,
    input  logic [3:0]            rxctrl3_in,
    output logic                  sync_n_out,
    output logic [1:0]            cgs_state_out,
    output logic [31:0]           data_out,
    output logic [3:0]            ctrl_out,
    output logic                  data_valid_out,
    output logic                  ilas_start_out,
    output logic [ERR_STAT_W-1:0] err_cnt_out
);

    localparam int unsigned KW = $clog2(CGS_K_WORDS + 1);
    localparam int unsigned LW = $clog2(SYNC_MIN_LOW + 1);
    localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

    localparam logic [KW-1:0] KMax = KW'(CGS_K_WORDS);
    localparam logic [LW-1:0] LMax = LW'(SYNC_MIN_LOW);
    localparam logic [EW-1:0] EMax = EW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StCheck = 2'b01,
        StData  = 2'b10
    } cgs_state_e;

    cgs_state_e            state_q, state_d;
    logic [KW-1:0]         k_cnt_q, k_cnt_d, k_inc;
    logic [LW-1:0]         low_cnt_q, low_cnt_d, low_inc;
    logic [EW-1:0]         err_run_q, err_run_d, err_inc;
    logic [ERR_STAT_W-1:0] err_cnt_q, err_cnt_d;
    logic                  sync_n_q, valid_q, valid_d, ilas_q, ilas_d;
    logic [31:0]           data_q;
    logic [3:0]            ctrl_q;

    logic err_word, k_word, r_word, link_down;

    always_comb begin
        err_word  = |(rxctrl1_in | rxctrl3_in);
        k_word    = !err_word && (rxctrl0_in == 4'hF) && (rxdata_in == 32'hBCBC_BCBC);
        r_word    = !err_word && rxctrl0_in[0] && (rxdata_in[7:0] == 8'h1C);
        link_down = !rx_reset_done_in || !rxbyteisaligned_in;

        k_inc   = (k_cnt_q == KMax) ? k_cnt_q : k_cnt_q + 1'b1;
        low_inc = (low_cnt_q == LMax) ? low_cnt_q : low_cnt_q + 1'b1;
        err_inc = (err_run_q == EMax) ? err_run_q : err_run_q + 1'b1;

        state_d   = state_q;
        k_cnt_d   = k_cnt_q;
        low_cnt_d = low_cnt_q;
        err_run_d = err_run_q;
        valid_d   = 1'b0;
        ilas_d    = 1'b0;

        err_cnt_d = err_cnt_q;
        if (err_word && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        if (link_down) begin
            // Held link-down keeps re-entering CS_INIT, so SYNC~ low time counts from link-up
            state_d   = StInit;
            k_cnt_d   = '0;
            low_cnt_d = '0;
            err_run_d = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    k_cnt_d   = k_word ? k_inc : '0;
                    low_cnt_d = low_inc;
                    if (k_word && (k_inc == KMax) && (low_inc == LMax)) begin
                        state_d   = StCheck;
                        k_cnt_d   = '0;
                        low_cnt_d = '0;
                        err_run_d = '0;
                    end
                end
                StCheck: begin
                    if (err_word) begin
                        err_run_d = err_inc;
                        if (err_inc == EMax) begin
                            state_d   = StInit;
                            err_run_d = '0;
                        end
                    end else if (r_word) begin
                        state_d   = StData;
                        err_run_d = '0;
                        valid_d   = 1'b1;
                        ilas_d    = 1'b1;
                    end else if (!k_word) begin
                        state_d   = StInit;
                        err_run_d = '0;
                    end
                end
                StData: begin
                    if (err_word && (err_inc == EMax)) begin
                        state_d   = StInit;
                        err_run_d = '0;
                    end else begin
                        valid_d = 1'b1;
                        if (err_word) begin
                            err_run_d = err_inc;
                        end
                    end
                end
                default: begin
                    state_d   = StInit;
                    k_cnt_d   = '0;
                    low_cnt_d = '0;
                    err_run_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge rxusrclk2_in or negedge rx_reset_n_in) begin
        if (!rx_reset_n_in) begin
            state_q   <= StInit;
            k_cnt_q   <= '0;
            low_cnt_q <= '0;
            err_run_q <= '0;
            err_cnt_q <= '0;
            sync_n_q  <= 1'b0;
            valid_q   <= 1'b0;
            ilas_q    <= 1'b0;
            data_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_cnt_q   <= k_cnt_d;
            low_cnt_q <= low_cnt_d;
            err_run_q <= err_run_d;
            err_cnt_q <= err_cnt_d;
            sync_n_q  <= (state_d != StInit);
            valid_q   <= valid_d;
            ilas_q    <= ilas_d;
            data_q    <= rxdata_in;
            ctrl_q    <= rxctrl0_in;
        end
    end

    assign sync_n_out     = sync_n_q;
    assign cgs_state_out  = state_q;
    assign data_out       = data_q;
    assign ctrl_out       = ctrl_q;
    assign data_valid_out = valid_q;
    assign ilas_start_out = ilas_q;
    assign err_cnt_out    = err_cnt_q;

endmodule
